// File: rtl/tx_size_clr_ctrl_if.sv
// Bus between the buffer-reservation logic, the TX transaction tracker and
// the TX packet data-size clear controller.
interface tx_size_clr_ctrl_if #(
  parameter int MAX_PEND = 4
);
  localparam int CW = $clog2(MAX_PEND + 1);

  logic          buff_resv;
  logic          tx_trans_act;
  logic          tx_abort;
  logic          tx_pack_ds_clr;
  logic          timeout_err;
  logic          pend_ovf;
  logic [CW-1:0] pend_cnt;

  modport master (
    output buff_resv, tx_trans_act, tx_abort,
    input  tx_pack_ds_clr, timeout_err, pend_ovf, pend_cnt
  );

  modport slave (
    input  buff_resv, tx_trans_act, tx_abort,
    output tx_pack_ds_clr, timeout_err, pend_ovf, pend_cnt
  );
endinterface

// File: rtl/tx_size_clr_ctrl.sv
// TX packet data-size clear controller: counts outstanding buffer
// reservations and, for each one, waits for a TX transaction to start and
// finish (or abort / time out), then strobes the clear for CLR_LEN cycles.
module tx_size_clr_ctrl #(
  parameter int MAX_PEND = 4,
  parameter int CLR_LEN  = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                n_rst,
  tx_size_clr_ctrl_if.slave   bus
);

  localparam int CW    = $clog2(MAX_PEND + 1);
  localparam int TW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int LW    = (CLR_LEN > 1) ? $clog2(CLR_LEN) : 1;
  localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_END   = 2'd2,
    CLEAR      = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] pend_cnt_q, pend_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [LW-1:0] clr_cnt_q, clr_cnt_d;
  logic          timeout_err_q, timeout_err_d;
  logic          pend_ovf_q, pend_ovf_d;
  logic          inc, dec, cnt_full;

  // Reservation accounting: a reservation arriving on the final clear cycle
  // is accepted even at full count because a slot frees up in that cycle.
  always_comb begin
    cnt_full   = (pend_cnt_q == CW'(MAX_PEND));
    dec        = (state_q == CLEAR) && (clr_cnt_q == LW'(CLR_LEN - 1));
    inc        = bus.buff_resv && (!cnt_full || dec);
    pend_ovf_d = bus.buff_resv && cnt_full && !dec;
    pend_cnt_d = pend_cnt_q;
    if (inc && !dec) begin
      pend_cnt_d = pend_cnt_q + 1'b1;
    end else if (dec && !inc) begin
      pend_cnt_d = pend_cnt_q - 1'b1;
    end
  end

  // Next-state logic for the per-reservation wait/clear sequence.
  always_comb begin
    state_d       = state_q;
    timer_d       = '0;
    clr_cnt_d     = '0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.buff_resv || (pend_cnt_q != '0)) begin
          state_d = WAIT_START;
        end
      end
      WAIT_START: begin
        timer_d = timer_q + 1'b1;
        if (bus.tx_abort) begin
          state_d = CLEAR;
        end else if (bus.tx_trans_act) begin
          state_d = WAIT_END;
        end else if ((TIMEOUT != 0) && (timer_q == TW'(TO_M1))) begin
          state_d       = CLEAR;
          timeout_err_d = 1'b1;
        end
      end
      WAIT_END: begin
        if (bus.tx_abort || !bus.tx_trans_act) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (dec) begin
          state_d = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and one-cycle status flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      pend_cnt_q    <= '0;
      timer_q       <= '0;
      clr_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
      pend_ovf_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_cnt_q    <= pend_cnt_d;
      timer_q       <= timer_d;
      clr_cnt_q     <= clr_cnt_d;
      timeout_err_q <= timeout_err_d;
      pend_ovf_q    <= pend_ovf_d;
    end
  end

  assign bus.tx_pack_ds_clr = (state_q == CLEAR);
  assign bus.timeout_err    = timeout_err_q;
  assign bus.pend_ovf       = pend_ovf_q;
  assign bus.pend_cnt       = pend_cnt_q;

endmodule

// File: tb/tb_tx_size_clr_ctrl.sv
// Bench for tx_size_clr_ctrl. Three instances cover different parameter
// sets: A (MAX_PEND=4, CLR_LEN=1, TIMEOUT=255), B (MAX_PEND=2, CLR_LEN=3,
// TIMEOUT=8), C (MAX_PEND=4, CLR_LEN=4, TIMEOUT=0). Observed output vector
// per cycle is {clr, timeout_err, pend_ovf, pend_cnt[2:0]}.
module tb_tx_size_clr_ctrl;

  logic clk;
  logic n_rst;
  int   tests;
  int   fails;

  tx_size_clr_ctrl_if #(.MAX_PEND(4)) ifa ();
  tx_size_clr_ctrl_if #(.MAX_PEND(2)) ifb ();
  tx_size_clr_ctrl_if #(.MAX_PEND(4)) ifc ();

  tx_size_clr_ctrl #(.MAX_PEND(4), .CLR_LEN(1), .TIMEOUT(255)) ua (
    .clk(clk), .n_rst(n_rst), .bus(ifa)
  );
  tx_size_clr_ctrl #(.MAX_PEND(2), .CLR_LEN(3), .TIMEOUT(8)) ub (
    .clk(clk), .n_rst(n_rst), .bus(ifb)
  );
  tx_size_clr_ctrl #(.MAX_PEND(4), .CLR_LEN(4), .TIMEOUT(0)) uc (
    .clk(clk), .n_rst(n_rst), .bus(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifa.buff_resv = 0; ifa.tx_trans_act = 0; ifa.tx_abort = 0;
    ifb.buff_resv = 0; ifb.tx_trans_act = 0; ifb.tx_abort = 0;
    ifc.buff_resv = 0; ifc.tx_trans_act = 0; ifc.tx_abort = 0;
  endtask

  // Reset holds every output at zero even with reservations requested.
  task automatic test_reset();
    logic [5:0] got;
    n_rst = 1'b0;
    clear_inputs();
    ifa.buff_resv = 1; ifb.buff_resv = 1; ifc.buff_resv = 1;
    repeat (2) step();
    for (int i = 0; i < 3; i++) begin
      got = (i == 0) ? {ifa.tx_pack_ds_clr, ifa.timeout_err, ifa.pend_ovf, 3'(ifa.pend_cnt)} :
            (i == 1) ? {ifb.tx_pack_ds_clr, ifb.timeout_err, ifb.pend_ovf, 3'(ifb.pend_cnt)} :
                       {ifc.tx_pack_ds_clr, ifc.timeout_err, ifc.pend_ovf, 3'(ifc.pend_cnt)};
      tests++;
      if (got !== 6'd0) begin
        fails++;
        $display("FAIL reset_hold inst%0d got=%b exp=%b", i, got, 6'd0);
      end
    end
    clear_inputs();
    @(negedge clk);
    n_rst = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      got = (i == 0) ? {ifa.tx_pack_ds_clr, ifa.timeout_err, ifa.pend_ovf, 3'(ifa.pend_cnt)} :
            (i == 1) ? {ifb.tx_pack_ds_clr, ifb.timeout_err, ifb.pend_ovf, 3'(ifb.pend_cnt)} :
                       {ifc.tx_pack_ds_clr, ifc.timeout_err, ifc.pend_ovf, 3'(ifc.pend_cnt)};
      tests++;
      if (got !== 6'd0) begin
        fails++;
        $display("FAIL reset_release inst%0d got=%b exp=%b", i, got, 6'd0);
      end
    end
  endtask

  // CLR_LEN=1: resv@c0, act c3..c6 -> clr only @c8, count 1 over c1..c8.
  task automatic test_basic();
    logic [5:0] exp_q[$];
    logic [5:0] got, exp;
    int e;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) begin
        got = {ifa.tx_pack_ds_clr, ifa.timeout_err, ifa.pend_ovf, 3'(ifa.pend_cnt)};
        exp = exp_q.pop_front();
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL basic c%0d got=%b exp=%b", c, got, exp);
        end
      end
      ifa.buff_resv    = (c == 0);
      ifa.tx_trans_act = (c >= 3 && c <= 6);
      e = c + 1;
      exp_q.push_back({(e == 8), 1'b0, 1'b0, 3'((e >= 1 && e <= 8) ? 1 : 0)});
      step();
    end
  endtask

  // CLR_LEN=3, two reservations, two bursts: two 3-cycle pulses split by
  // exactly one IDLE cycle, count 1 -> 2 -> 1 -> 0.
  task automatic test_back_to_back();
    logic [5:0] exp_q[$];
    logic [5:0] got, exp;
    int e;
    int cnt;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) begin
        got = {ifb.tx_pack_ds_clr, ifb.timeout_err, ifb.pend_ovf, 3'(ifb.pend_cnt)};
        exp = exp_q.pop_front();
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL back_to_back c%0d got=%b exp=%b", c, got, exp);
        end
      end
      ifb.buff_resv    = (c == 0 || c == 2);
      ifb.tx_trans_act = (c == 2 || c == 3 || c == 10);
      e   = c + 1;
      cnt = (e <= 2) ? 1 : (e <= 7) ? 2 : (e <= 14) ? 1 : 0;
      exp_q.push_back({((e >= 5 && e <= 7) || (e >= 12 && e <= 14)), 1'b0, 1'b0, 3'(cnt)});
      step();
    end
  endtask

  // MAX_PEND=2: third reservation dropped (ovf @c3), timeout clear @c9 with
  // timeout_err, reservation on last clear cycle accepted at full count,
  // then two aborts from WAIT_START drain the count.
  task automatic test_overflow();
    logic [5:0] exp_q[$];
    logic [5:0] got, exp;
    int e;
    int cnt;
    for (int c = 0; c <= 23; c++) begin
      if (c > 0) begin
        got = {ifb.tx_pack_ds_clr, ifb.timeout_err, ifb.pend_ovf, 3'(ifb.pend_cnt)};
        exp = exp_q.pop_front();
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL overflow c%0d got=%b exp=%b", c, got, exp);
        end
      end
      ifb.buff_resv = (c == 0 || c == 1 || c == 2 || c == 11);
      ifb.tx_abort  = (c == 13 || c == 18);
      e   = c + 1;
      cnt = (e == 1) ? 1 : (e <= 16) ? 2 : (e <= 21) ? 1 : 0;
      exp_q.push_back({((e >= 9 && e <= 11) || (e >= 14 && e <= 16) || (e >= 19 && e <= 21)),
                       (e == 9), (e == 3), 3'(cnt)});
      step();
    end
  endtask

  // Abort in WAIT_END gives a 3-cycle pulse even with act still high;
  // abort and act in IDLE afterwards have no effect.
  task automatic test_abort();
    logic [5:0] exp_q[$];
    logic [5:0] got, exp;
    int e;
    for (int c = 0; c <= 13; c++) begin
      if (c > 0) begin
        got = {ifb.tx_pack_ds_clr, ifb.timeout_err, ifb.pend_ovf, 3'(ifb.pend_cnt)};
        exp = exp_q.pop_front();
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL abort c%0d got=%b exp=%b", c, got, exp);
        end
      end
      ifb.buff_resv    = (c == 0);
      ifb.tx_trans_act = (c >= 2 && c <= 8);
      ifb.tx_abort     = (c == 4 || c == 10);
      e = c + 1;
      exp_q.push_back({(e >= 5 && e <= 7), 1'b0, 1'b0, 3'((e >= 1 && e <= 7) ? 1 : 0)});
      step();
    end
  endtask

  // TIMEOUT=0: 100 cycles in WAIT_START with no error, then a normal
  // transaction ends in a 4-cycle pulse.
  task automatic test_timeout_disabled();
    logic [5:0] exp_q[$];
    logic [5:0] got, exp;
    int e;
    for (int c = 0; c <= 110; c++) begin
      if (c > 0) begin
        got = {ifc.tx_pack_ds_clr, ifc.timeout_err, ifc.pend_ovf, 3'(ifc.pend_cnt)};
        exp = exp_q.pop_front();
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL timeout_dis c%0d got=%b exp=%b", c, got, exp);
        end
      end
      ifc.buff_resv    = (c == 0);
      ifc.tx_trans_act = (c == 101);
      e = c + 1;
      exp_q.push_back({(e >= 103 && e <= 106), 1'b0, 1'b0, 3'((e >= 1 && e <= 106) ? 1 : 0)});
      step();
    end
  endtask

  // CLR_LEN=4: reset on the 2nd clear cycle drops everything at once and
  // nothing resumes without a new reservation.
  task automatic test_reset_mid_clear();
    logic [5:0] exp_q[$];
    logic [5:0] got, exp;
    int e;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) begin
        got = {ifc.tx_pack_ds_clr, ifc.timeout_err, ifc.pend_ovf, 3'(ifc.pend_cnt)};
        exp = exp_q.pop_front();
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL rst_mid c%0d got=%b exp=%b", c, got, exp);
        end
      end
      if (c == 5) break;
      ifc.buff_resv    = (c == 0);
      ifc.tx_trans_act = (c == 2);
      e = c + 1;
      exp_q.push_back({(e >= 4 && e <= 5), 1'b0, 1'b0, 3'((e >= 1 && e <= 5) ? 1 : 0)});
      step();
    end
    #1;
    n_rst = 1'b0;
    #1;
    got = {ifc.tx_pack_ds_clr, ifc.timeout_err, ifc.pend_ovf, 3'(ifc.pend_cnt)};
    tests++;
    if (got !== 6'd0) begin
      fails++;
      $display("FAIL rst_mid_async got=%b exp=%b", got, 6'd0);
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      got = {ifc.tx_pack_ds_clr, ifc.timeout_err, ifc.pend_ovf, 3'(ifc.pend_cnt)};
      tests++;
      if (got !== 6'd0) begin
        fails++;
        $display("FAIL rst_mid_after c%0d got=%b exp=%b", c, got, 6'd0);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    n_rst = 1'b0;
    clear_inputs();
    test_reset();
    test_basic();
    clear_inputs();
    test_back_to_back();
    clear_inputs();
    test_overflow();
    clear_inputs();
    test_abort();
    clear_inputs();
    test_timeout_disabled();
    clear_inputs();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

endmodule
